// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, counter width, frame size
// and the bit-period helper. The UART transmitter imports this package too.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Wide enough for a 5208-cycle bit period (50 MHz / 9600 baud).
  localparam int CNT_W          = 14;
  localparam int UART_DATA_BITS = 8;

  // Number of clk cycles in one bit period.
  function automatic int calc_count_max(input int fre, input int baud_rate);
    return fre / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// The reset value defaults to all ones, which matches an idle UART line.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two register stages give a metastable first stage a full cycle to settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first.
// The bit timer restarts on every start edge. The start bit is sampled HALF
// cycles after the edge, and each later bit is sampled one full period after
// the previous sample, so every sample lands mid-bit.
// A low stop bit raises frame_err and parks the receiver in BREAK until the
// line returns high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FRE       = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int COUNT_MAX = calc_count_max(FRE, BAUD_RATE);
  localparam int HALF      = COUNT_MAX / 2;
  localparam int IDX_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(COUNT_MAX - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  rx_state_t            state;
  logic [CNT_W-1:0]     count;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;

  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx_in),
    .q    (rx_s)
  );

  // Receive FSM. The count register clears on every state transition, and
  // all outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (count == HALF_LAST) begin
            count <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              // The line went high again before mid-start-bit, so this was a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        DATA: begin
          if (count == BIT_LAST) begin
            count <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        STOP: begin
          if (count == BIT_LAST) begin
            count <= '0;
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        BREAK: begin
          count <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with FRE=16 and BAUD_RATE=1, so each bit
// lasts 16 clk and HALF is 8.
module tb_uart_rx;

  localparam int BIT  = 16;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int valid_cnt = 0;
  int ferr_cnt  = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;
  logic [7:0] log_q[$];

  uart_rx #(
    .FRE      (16),
    .BAUD_RATE(1),
    .DATA_BITS(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Watchdog: the run must always end.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1);
  end

  // Monitor: counts the pulses, logs the received bytes, and checks that the
  // pulses are exclusive and last exactly one cycle.
  always @(negedge clk) begin
    if (rx_valid || frame_err) begin
      checks++;
      if (rx_valid && frame_err) begin
        errors++;
        $display("FAIL pulse_overlap: actual rx_valid=1 frame_err=1, required never both");
      end
      checks++;
      if ((rx_valid && prev_valid) || (frame_err && prev_ferr)) begin
        errors++;
        $display("FAIL pulse_width: actual pulse longer than 1 cycle, required 1 cycle");
      end
    end
    if (rx_valid) begin
      valid_cnt++;
      log_q.push_back(rx_data);
    end
    if (frame_err) ferr_cnt++;
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
  end

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_hex(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%02h required=0x%02h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_time(input logic v);
    rx_in = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(stop_val);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, f0, lat, busy_cycles;

    // Each vector: the byte to send, its stop-bit value, and the expected
    // change in rx_valid pulses, frame_err pulses, and the rx_data value.
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[3] = '{8'h55, 1'b1, 1, 0, 8'h55};
    vecs[4] = '{8'h01, 1'b1, 1, 0, 8'h01};
    vecs[5] = '{8'h80, 1'b1, 1, 0, 8'h80};

    rx_in = 1'b1;
    @(negedge clk);
    do_reset();
    @(negedge clk);
    check_hex("reset_rx_data", rx_data, 8'h00);
    check_int("reset_rx_valid", int'(rx_valid), 0);
    check_int("reset_frame_err", int'(frame_err), 0);
    check_int("reset_busy", int'(busy), 0);
    $display("reset: rx_data=0x%02h busy=%0d", rx_data, busy);

    // Table-driven frames, with the line idle between them.
    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      if (!vecs[i].stop) begin
        rx_in = 1'b0;
        repeat (40) @(negedge clk);
      end
      idle(20);
      check_int($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
      check_int($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check_hex($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
      check_int($sformatf("vec%0d_busy", i), int'(busy), 0);
      $display("vec%0d: sent=0x%02h stop=%0d rx_data=0x%02h valid=%0d ferr=%0d",
               i, vecs[i].data, vecs[i].stop, rx_data, valid_cnt - v0, ferr_cnt - f0);
    end

    // Back-to-back frames with no idle between them.
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    check_int("b2b_valid", valid_cnt - v0, 2);
    if (log_q.size() >= 2) begin
      check_hex("b2b_first", log_q[log_q.size()-2], 8'h00);
      check_hex("b2b_second", log_q[log_q.size()-1], 8'hFF);
    end else begin
      check_int("b2b_log_size", log_q.size(), 2);
    end
    $display("b2b: pulses=%0d rx_data=0x%02h", valid_cnt - v0, rx_data);

    // A 3-cycle glitch is rejected.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    busy_cycles = 0;
    rx_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    rx_in = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    checks++;
    if (busy_cycles < 1 || busy_cycles > HALF + 2) begin
      errors++;
      $display("FAIL glitch_busy: actual=%0d required=1..%0d", busy_cycles, HALF + 2);
    end
    check_int("glitch_valid", valid_cnt - v0, 0);
    check_int("glitch_ferr", ferr_cnt - f0, 0);
    check_int("glitch_busy_end", int'(busy), 0);
    $display("glitch: busy_cycles=%0d", busy_cycles);

    // Latency from the falling edge of the start bit to rx_valid.
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (lat < 300) begin
          @(posedge clk);
          lat++;
          #1;
          if (rx_valid) break;
        end
      end
    join
    idle(20);
    checks++;
    if (lat < 154 || lat > 156) begin
      errors++;
      $display("FAIL latency: actual=%0d required=155+/-1", lat);
    end
    check_hex("latency_data", rx_data, 8'hA5);
    $display("latency: %0d clk", lat);

    // Reset during data bit 4 of 0x5A, then receive 0xC3.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(logic'((8'h5A >> i) & 8'h01));
    rx_in = 1'b1;
    repeat (HALF) @(negedge clk);
    do_reset();
    @(negedge clk);
    check_hex("midreset_rx_data", rx_data, 8'h00);
    check_int("midreset_busy", int'(busy), 0);
    idle(20);
    check_int("midreset_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    send_frame(8'hC3, 1'b1);
    idle(20);
    check_int("midreset_valid", valid_cnt - v0, 1);
    check_hex("midreset_data", rx_data, 8'hC3);
    $display("midreset: rx_data=0x%02h", rx_data);

    // Line held low from reset: exactly one frame_err, then BREAK until the line goes high.
    rx_in = 1'b0;
    do_reset();
    v0 = valid_cnt;
    f0 = ferr_cnt;
    repeat (BIT * 10 + 40) @(negedge clk);
    check_int("lowline_ferr", ferr_cnt - f0, 1);
    check_int("lowline_valid", valid_cnt - v0, 0);
    check_int("lowline_busy_break", int'(busy), 1);
    check_hex("lowline_data", rx_data, 8'h00);
    idle(6);
    check_int("lowline_busy_idle", int'(busy), 0);
    $display("lowline: ferr=%0d busy=%0d", ferr_cnt - f0, busy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
